acorn128_decrypt: RTL and testbench

Bit-serial ACORN-128 decryption and tag-verification core. It loads the 293-bit cipher state produced after initialization and associated-data processing, and decrypts a ciphertext byte stream one state-update step per clock. It then runs the 256-step padding and 768-step finalization phases, produces the 128-bit tag and compares it against a supplied tag. It is the receive-side counterpart of the encryption datapath and sits downstream of the `initialization` block.

---
 rtl/acorn128_pkg.sv | 46 ++++
 rtl/acorn128_step.sv | 35 +++
 rtl/acorn128_decrypt.sv | 182 ++++++++++++++++++
 tb/tb_acorn128_decrypt.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// rtl/acorn128_pkg.sv - shared ACORN-128 constants, FSM encoding, step taps and helpers
package acorn128_pkg;

    localparam int STATE_W     = 293;
    localparam int TAG_W       = 128;
    localparam int PAD_STEPS   = 256;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_START   = 640;
    localparam int CNT_W       = 10;

    // State-bit taps used by the step function
    localparam int S_0   = 0;
    localparam int S_12  = 12;
    localparam int S_23  = 23;
    localparam int S_61  = 61;
    localparam int S_66  = 66;
    localparam int S_107 = 107;
    localparam int S_111 = 111;
    localparam int S_154 = 154;
    localparam int S_160 = 160;
    localparam int S_193 = 193;
    localparam int S_196 = 196;
    localparam int S_230 = 230;
    localparam int S_235 = 235;
    localparam int S_244 = 244;
    localparam int S_289 = 289;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CT_WAIT  = 3'd1,
        ST_CT_SHIFT = 3'd2,
        ST_PT_OUT   = 3'd3,
        ST_PAD      = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } fsm_t;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn128_step.sv
// rtl/acorn128_step.sv - combinational single ACORN-128 state-update step
module acorn128_step
    import acorn128_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               m,
    input  logic               ca,
    input  logic               cb,
    output logic [STATE_W-1:0] next_state,
    output logic               ks
);

    logic [STATE_W-1:0] w_s;
    logic               w_f;

    // LFSR feedback updates in order, then keystream and feedback bit; ks never depends on m
    always_comb begin
        w_s        = state;
        w_s[S_289] = w_s[S_289] ^ w_s[S_235] ^ w_s[S_230];
        w_s[S_230] = w_s[S_230] ^ w_s[S_196] ^ w_s[S_193];
        w_s[S_193] = w_s[S_193] ^ w_s[S_160] ^ w_s[S_154];
        w_s[S_154] = w_s[S_154] ^ w_s[S_111] ^ w_s[S_107];
        w_s[S_107] = w_s[S_107] ^ w_s[S_66]  ^ w_s[S_61];
        w_s[S_61]  = w_s[S_61]  ^ w_s[S_23]  ^ w_s[S_0];
        ks  = w_s[S_12] ^ w_s[S_154]
            ^ maj(w_s[S_235], w_s[S_61], w_s[S_193])
            ^ ch(w_s[S_230], w_s[S_111], w_s[S_66]);
        w_f = w_s[S_0] ^ ~w_s[S_107]
            ^ maj(w_s[S_244], w_s[S_23], w_s[S_160])
            ^ (ca & w_s[S_196]) ^ (cb & ks);
    end

    assign next_state = {w_f ^ m, w_s[STATE_W-1:1]};

endmodule

// File: rtl/acorn128_decrypt.sv
// rtl/acorn128_decrypt.sv - bit-serial ACORN-128 decryption and tag verification
module acorn128_decrypt #(
    parameter int STATE_W = acorn128_pkg::STATE_W,
    parameter int TAG_W   = acorn128_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic               msg_empty,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic               ct_valid,
    input  logic [7:0]         ct_data,
    input  logic               ct_last,
    output logic               ct_ready,
    output logic               pt_valid,
    output logic [7:0]         pt_data,
    output logic               busy,
    output logic               done,
    output logic               tag_ok,
    output logic [TAG_W-1:0]   tag_out
);
    import acorn128_pkg::*;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [STATE_W-1:0] r_state;
    logic [TAG_W-1:0]   r_tag_exp;
    logic [TAG_W-1:0]   r_tag_out;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_ct_byte;
    logic               r_ct_last;
    logic [7:0]         r_pt_byte;
    logic               r_tag_ok;

    logic               w_m;
    logic               w_ca;
    logic               w_cb;
    logic               w_step;
    logic               w_ks;
    logic               w_p;
    logic               w_load;
    logic               w_pad_end;
    logic               w_final_end;
    logic [STATE_W-1:0] w_next_state;
    logic [TAG_W-1:0]   w_tag_next;

    acorn128_step u_step (
        .state      (r_state),
        .m          (w_m),
        .ca         (w_ca),
        .cb         (w_cb),
        .next_state (w_next_state),
        .ks         (w_ks)
    );

    assign w_p         = r_ct_byte[r_bit] ^ w_ks;
    assign w_load      = start && (r_fsm == ST_IDLE || r_fsm == ST_DONE);
    assign w_pad_end   = (r_cnt == CNT_W'(PAD_STEPS - 1));
    assign w_final_end = (r_cnt == CNT_W'(FINAL_STEPS - 1));
    assign w_tag_next  = {w_ks, r_tag_out[TAG_W-1:1]};

    assign ct_ready = (r_fsm == ST_CT_WAIT);
    assign pt_valid = (r_fsm == ST_PT_OUT);
    assign busy     = (r_fsm != ST_IDLE) && (r_fsm != ST_DONE);
    assign done     = (r_fsm == ST_DONE);
    assign pt_data  = r_pt_byte;
    assign tag_ok   = r_tag_ok;
    assign tag_out  = r_tag_out;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state and step-input selection per phase
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_m       = 1'b0;
        w_ca      = 1'b0;
        w_cb      = 1'b0;
        w_step    = 1'b0;
        case (r_fsm)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_fsm_nxt = msg_empty ? ST_PAD : ST_CT_WAIT;
                end
            end
            ST_CT_WAIT: begin
                if (ct_valid) begin
                    w_fsm_nxt = ST_CT_SHIFT;
                end
            end
            ST_CT_SHIFT: begin
                w_step = 1'b1;
                w_ca   = 1'b1;
                w_m    = w_p;
                if (r_bit == 3'd7) begin
                    w_fsm_nxt = ST_PT_OUT;
                end
            end
            ST_PT_OUT: begin
                w_fsm_nxt = r_ct_last ? ST_PAD : ST_CT_WAIT;
            end
            ST_PAD: begin
                w_step = 1'b1;
                w_m    = (r_cnt == '0);
                w_ca   = (r_cnt < CNT_W'(PAD_STEPS / 2));
                if (w_pad_end) begin
                    w_fsm_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_step = 1'b1;
                w_ca   = 1'b1;
                w_cb   = 1'b1;
                if (w_final_end) begin
                    w_fsm_nxt = ST_DONE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    // Cipher state, byte capture/assembly, phase counter and tag collection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= '0;
            r_tag_exp <= '0;
            r_tag_out <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_ct_byte <= '0;
            r_ct_last <= 1'b0;
            r_pt_byte <= '0;
            r_tag_ok  <= 1'b0;
        end else begin
            if (w_load) begin
                r_state   <= state_in;
                r_tag_exp <= tag_in;
                r_tag_out <= '0;
                r_tag_ok  <= 1'b0;
            end else if (w_step) begin
                r_state <= w_next_state;
            end

            if (r_fsm == ST_CT_WAIT && ct_valid) begin
                r_ct_byte <= ct_data;
                r_ct_last <= ct_last;
                r_bit     <= '0;
            end

            if (r_fsm == ST_CT_SHIFT) begin
                r_pt_byte[r_bit] <= w_p;
                r_bit            <= r_bit + 3'd1;
            end

            // Counter restarts on every phase change so PAD and FINAL each begin at 0
            if (w_fsm_nxt != r_fsm) begin
                r_cnt <= '0;
            end else if (r_fsm == ST_PAD || r_fsm == ST_FINAL) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Tag bits arrive LSB first, so shifting in from the top leaves step 640 in bit 0
            if (r_fsm == ST_FINAL && r_cnt >= CNT_W'(TAG_START)) begin
                r_tag_out <= w_tag_next;
            end
            if (r_fsm == ST_FINAL && w_final_end) begin
                r_tag_ok <= (w_tag_next == r_tag_exp);
            end
        end
    end

endmodule

// File: tb/tb_acorn128_decrypt.sv
// tb/tb_acorn128_decrypt.sv - directed self-checking bench for acorn128_decrypt
module tb_acorn128_decrypt;

    logic         clk;
    logic         rst;
    logic         start;
    logic [292:0] state_in;
    logic         msg_empty;
    logic [127:0] tag_in;
    logic         ct_valid;
    logic [7:0]   ct_data;
    logic         ct_last;
    logic         ct_ready;
    logic         pt_valid;
    logic [7:0]   pt_data;
    logic         busy;
    logic         done;
    logic         tag_ok;
    logic [127:0] tag_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] g_ct[4];
    logic [7:0] g_pt[4];

    acorn128_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .msg_empty (msg_empty),
        .tag_in    (tag_in),
        .ct_valid  (ct_valid),
        .ct_data   (ct_data),
        .ct_last   (ct_last),
        .ct_ready  (ct_ready),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference step: returns {ks, shifted state with feedback f in bit 292}; m is applied by the caller
    function automatic logic [293:0] mstep(input logic [292:0] si, input logic ca, input logic cb);
        logic [292:0] s;
        logic         ks;
        logic         f;
        s = si;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        ks = s[12] ^ s[154] ^ ((s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]))
           ^ (s[230] ? s[111] : s[66]);
        f  = s[0] ^ ~s[107] ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]))
           ^ (ca & s[196]) ^ (cb & ks);
        return {ks, f, s[292:1]};
    endfunction

    task automatic model_run(input logic [292:0] st, input int n, output logic [127:0] tag);
        logic [292:0] s;
        logic [293:0] r;
        logic         p;
        s   = st;
        tag = '0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                r = mstep(s, 1'b1, 1'b0);
                p = g_ct[i][b] ^ r[293];
                g_pt[i][b] = p;
                s = r[292:0];
                s[292] = s[292] ^ p;
            end
        end
        for (int k = 0; k < 256; k++) begin
            r = mstep(s, (k < 128), 1'b0);
            s = r[292:0];
            s[292] = s[292] ^ (k == 0);
        end
        for (int k = 0; k < 768; k++) begin
            r = mstep(s, 1'b1, 1'b1);
            if (k >= 640) tag[k-640] = r[293];
            s = r[292:0];
        end
    endtask

    // Called at a negedge; waits for ct_ready, optionally idles, sends one byte and checks its plaintext
    task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] exp, input int gap);
        int   k;
        logic hold_ok;
        k = 0;
        while (!ct_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ct_ready_wait", ct_ready, 1);
        hold_ok = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (!ct_ready || pt_valid) hold_ok = 1'b0;
        end
        if (gap > 0) chk("gap_ready_hold", hold_ok, 1);
        ct_data  = d;
        ct_last  = last;
        ct_valid = 1'b1;
        @(negedge clk);
        ct_valid = 1'b0;
        k = 1;
        while (!pt_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pt_latency", k, 9);
        chk("pt_data", pt_data, exp);
    endtask

    task automatic run_msg(input logic [292:0] st, input int n, input logic [127:0] tin,
                           input int gap, input logic exp_ok, input logic [127:0] exp_tag);
        int k;
        @(negedge clk);
        state_in  = st;
        msg_empty = (n == 0);
        tag_in    = tin;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) send_byte(g_ct[i], (i == n - 1), g_pt[i], gap);
        k = 0;
        while (!done && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("done", done, 1);
        chk("tag_out", tag_out, exp_tag);
        chk("tag_ok", tag_ok, exp_ok);
        chk("busy_in_done", busy, 0);
    endtask

    localparam logic [292:0] ST0 = '0;
    localparam logic [292:0] ST1 = {5'h15, {9{32'hDEADBEEF}}};

    initial begin
        logic [127:0] tag0;
        logic [127:0] tag1;
        logic [127:0] tag2;
        int           k;
        logic         seen;

        rst = 1'b0; start = 1'b0; state_in = '0; msg_empty = 1'b0; tag_in = '0;
        ct_valid = 1'b0; ct_data = '0; ct_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ct_ready, pt_valid, busy, done, tag_ok, pt_data, tag_out}, 0);
        rst = 1'b1;

        // Empty message from the all-zero state: latency and tag
        model_run(ST0, 0, tag0);
        @(negedge clk);
        state_in = ST0; msg_empty = 1'b1; tag_in = tag0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk("busy_pad", busy, 1);
        while (!done && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("empty_latency", k, 1025);
        chk("empty_tag_out", tag_out, tag0);
        chk("empty_tag_ok", tag_ok, 1);

        // Four-byte message, back to back
        g_ct[0] = 8'h00; g_ct[1] = 8'h01; g_ct[2] = 8'h7F; g_ct[3] = 8'hFF;
        model_run(ST1, 4, tag1);
        run_msg(ST1, 4, tag1, 0, 1'b1, tag1);

        // Wrong expected tag: plaintext unchanged, tag_ok low
        run_msg(ST1, 4, tag1 ^ 128'd1, 0, 1'b0, tag1);

        // Idle gaps between bytes give the same result
        run_msg(ST1, 4, tag1, 20, 1'b1, tag1);

        // Reset during CT_SHIFT at bit 3
        @(negedge clk);
        state_in = ST1; msg_empty = 1'b0; tag_in = tag1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("shift_rst_ready", ct_ready, 1);
        ct_data = 8'h5A; ct_last = 1'b1; ct_valid = 1'b1;
        @(negedge clk);
        ct_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("shift_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("shift_rst_outputs", {ct_ready, pt_valid, busy, done, tag_ok, pt_data, tag_out}, 0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (pt_valid || busy) seen = 1'b1;
        end
        chk("shift_rst_quiet", seen, 0);

        // Reset during FINAL step 400
        @(negedge clk);
        state_in = ST1; msg_empty = 1'b1; tag_in = tag1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (656) @(negedge clk);
        chk("final_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("final_rst_outputs", {ct_ready, pt_valid, busy, done, tag_ok, pt_data, tag_out}, 0);
        rst = 1'b1;

        // Clean run after the resets
        run_msg(ST1, 4, tag1, 0, 1'b1, tag1);

        // start during PAD and ct_valid during FINAL are ignored
        model_run(ST1, 0, tag2);
        @(negedge clk);
        state_in = ST1; msg_empty = 1'b1; tag_in = tag2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        state_in = ~ST1; msg_empty = 1'b0; tag_in = ~tag2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        ct_data = 8'hA5; ct_last = 1'b1; ct_valid = 1'b1;
        @(negedge clk);
        ct_valid = 1'b0;
        k = 601;
        while (!done && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("ignore_latency", k, 1025);
        chk("ignore_tag_out", tag_out, tag2);
        chk("ignore_tag_ok", tag_ok, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
